// File: rtl/descontador_duzia_pkg.sv
// Shared types and defaults for the dozen/unit down-counter slice.
package descontador_duzia_pkg;

    localparam int W                  = 4;
    localparam int DOZEN_MOD_DEFAULT  = 12;
    localparam int DECADE_MOD_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Out-of-range presets saturate to the largest legal stage value.
    function automatic logic [W-1:0] clamp_preset(input logic [W-1:0] value, input int modulus);
        if (int'(value) >= modulus) begin
            return W'(modulus - 1);
        end
        return value;
    endfunction

endpackage

// File: rtl/descontador_duzia_if.sv
// Load/enable/status bundle between a controller and descontador_duzia.
interface descontador_duzia_if;
    import descontador_duzia_pkg::*;

    logic         load;
    logic [W-1:0] load_units;
    logic [W-1:0] load_dozens;
    logic         enable;
    logic [W-1:0] units_out;
    logic [W-1:0] dozens_out;
    logic         borrow_out;
    logic         busy;
    logic         done;

    modport master (
        output load, load_units, load_dozens, enable,
        input  units_out, dozens_out, borrow_out, busy, done
    );

    modport slave (
        input  load, load_units, load_dozens, enable,
        output units_out, dozens_out, borrow_out, busy, done
    );

endinterface

// File: rtl/descontador_duzia_contador_decrescente.sv
// Single modulo-MOD down-counting stage with load, enable and wrap borrow.
module contador_decrescente
    import descontador_duzia_pkg::*;
#(
    parameter int MOD   = DOZEN_MOD_DEFAULT,
    parameter int WIDTH = W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

    assign borrow = enable && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= (count == '0) ? TOP : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/descontador_duzia.sv
// Loadable dozens/units down-counter with IDLE/RUN/DONE tracking.
// Define DESCONTADOR_AUTORELOAD_EN to restart from the saved preset after each completion.
module descontador_duzia
    import descontador_duzia_pkg::*;
#(
    parameter int DOZEN_MOD  = DOZEN_MOD_DEFAULT,
    parameter int DECADE_MOD = DECADE_MOD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    descontador_duzia_if.slave bus
);

    state_t       state;
    logic         busy_r;
    logic         done_r;
    logic [W-1:0] units;
    logic [W-1:0] dozens;
    logic [W-1:0] units_pre;
    logic [W-1:0] dozens_pre;
    logic [W-1:0] units_src;
    logic [W-1:0] dozens_src;
    logic         preset_zero;
    logic         run_step;
    logic         terminal;
    logic         units_borrow;
    logic         dozens_borrow_unused;
    logic         stage_load;
    logic         reload;

    assign units_pre   = clamp_preset(bus.load_units, DOZEN_MOD);
    assign dozens_pre  = clamp_preset(bus.load_dozens, DECADE_MOD);
    assign preset_zero = (units_pre == '0) && (dozens_pre == '0);
    assign run_step    = (state == RUN) && bus.enable && !bus.load;
    assign terminal    = run_step && (units == W'(1)) && (dozens == '0);

`ifdef DESCONTADOR_AUTORELOAD_EN
    logic [W-1:0] saved_units;
    logic [W-1:0] saved_dozens;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_units  <= '0;
            saved_dozens <= '0;
        end else if (bus.load) begin
            saved_units  <= units_pre;
            saved_dozens <= dozens_pre;
        end
    end

    // A zero preset must not reload, otherwise DONE would repeat forever.
    assign reload     = (state == DONE) && !bus.load && ((saved_units != '0) || (saved_dozens != '0));
    assign units_src  = bus.load ? units_pre  : saved_units;
    assign dozens_src = bus.load ? dozens_pre : saved_dozens;
`else
    assign reload     = 1'b0;
    assign units_src  = units_pre;
    assign dozens_src = dozens_pre;
`endif

    assign stage_load = bus.load || reload;

    contador_decrescente #(.MOD(DOZEN_MOD), .WIDTH(W)) u_units (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (stage_load),
        .load_value (units_src),
        .enable     (run_step),
        .count      (units),
        .borrow     (units_borrow)
    );

    contador_decrescente #(.MOD(DECADE_MOD), .WIDTH(W)) u_dozens (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (stage_load),
        .load_value (dozens_src),
        .enable     (units_borrow),
        .count      (dozens),
        .borrow     (dozens_borrow_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.load) begin
            state  <= preset_zero ? DONE : RUN;
            busy_r <= !preset_zero;
            done_r <= preset_zero;
        end else begin
            case (state)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                RUN: begin
                    if (terminal) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= reload ? RUN : IDLE;
                    busy_r <= reload;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.units_out  = units;
    assign bus.dozens_out = dozens;
    assign bus.borrow_out = units_borrow;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: doc/descontador_duzia.md
# descontador_duzia

Loadable cascaded down-counter that counts a preset quantity of dozens and units back to zero. A mod-12 units stage decrements every enabled cycle; its borrow decrements a mod-10 dozens stage. A small FSM tracks the run and flags completion. It is the counting-down complement of the team's dozen up-counter and is used as a batch/timeout countdown in the same designs.

## Interface
- DOZEN_MOD, 12, modulus of the units stage
- DECADE_MOD, 10, modulus of the dozens stage
- W, 4, width of each stage
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle load strobe; accepted in any state
- load_units  in  W  preset units, 0..DOZEN_MOD-1
- load_dozens  in  W  preset dozens, 0..DECADE_MOD-1
- enable  in  1  decrement permit while running
- units_out  out  W  units stage value
- dozens_out  out  W  dozens stage value
- borrow_out  out  1  combinational: RUN && enable && units_out==0 && !load
- busy  out  1  high in RUN
- done  out  1  high for exactly one cycle in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset (async, rst_n=0): state IDLE; units_out=0, dozens_out=0, busy=0, done=0, saved preset=0.
- load has priority over enable in every state.
  - Presets out of range are clamped: units ≥ DOZEN_MOD → DOZEN_MOD-1; dozens ≥ DECADE_MOD → DECADE_MOD-1.
  - The clamped value is written to both stages and to the saved preset.
  - Next state is RUN, or DONE if the clamped value is 0:0.
- RUN, enable=1, no load:
  - Units decrements.
  - Units at 0 wraps to DOZEN_MOD-1 and dozens decrements (borrow).
  - At dozens=0 and units=1, the stages become 0:0 and the state goes to DONE on the same edge.
- RUN, enable=0: values hold.
- DONE: done=1 and outputs are 0:0. The next edge goes to IDLE unless load is present.
- IDLE: values hold at 0:0. enable is ignored.
- Dozens never underflow: no decrement occurs in IDLE or DONE.

## Timing
- Load at edge N: outputs show the clamped preset after edge N; busy=1 from N.
- Total count V = 12·dozens + units. With enable held high, the stages reach 0:0 on the V-th enabled edge after the load.
- done is high during the cycle following the terminal edge, concurrent with outputs 0:0. busy drops on that same edge.
- borrow_out is valid in the same cycle as units_out==0 and precedes the dozens decrement by one edge.
- Load during RUN restarts from the new preset with no extra cycle. An enable in that cycle is discarded.
- rst_n asserted mid-run clears everything immediately. The run is lost and done does not pulse.

## Configuration
- DESCONTADOR_AUTORELOAD_EN defined:
  - From DONE, the next edge reloads the saved preset and enters RUN. done still pulses one cycle per completion.
  - If the saved preset is 0:0, the FSM goes to IDLE instead, so it does not loop.
- Macro undefined: DONE always returns to IDLE. The saved-preset register is not synthesised.

## Structure
- Shared package: state enum (IDLE/RUN/DONE), DOZEN_MOD/DECADE_MOD defaults, and W.
- One sub-module, contador_decrescente:
  - Parameterised modulus, decrement-with-wrap stage with load, enable and a borrow output.
  - Instantiated twice. The units borrow drives the dozens enable.
- The FSM and clamp logic live in the top level.

## Test plan
- Reset, load 1:3, enable high → outputs 1:3,1:2,1:1,1:0,0:11,…,0:1,0:0. Stages reach 0:0 on the 15th edge; done is high in exactly one cycle; borrow_out is high only while at 1:0.
- Load 0:5, enable toggling 1,0,1,0… → 0:0 after 5 enabled edges (10 clocks); values hold on enable=0 cycles.
- Load 0:0 → done=1 the following cycle, busy never high; load 15:12 → clamps to 9:11.
- Load 2:0 and run 4 edges, then load 0:2 → next outputs 0:2, then done after 2 more edges.
- rst_n low for one cycle mid-run at 0:7 → outputs 0:0 immediately, IDLE, done stays 0; clk edges during reset have no effect.
- With DESCONTADOR_AUTORELOAD_EN, load 0:3 and keep enable high → done pulses every 4 cycles, and outputs cycle 0:3,0:2,0:1,0:0,0:3…
